// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM,
// valid/ready output holding register with framing and overrun flags.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_rxs;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;

    logic w_stop_tick;
    logic w_byte_done;
    logic w_frame_bad;

    // Stop-bit sample cycle: the line level decides between delivery and framing error.
    assign w_stop_tick = (r_state == S_STOP) && (r_timer == FULL_M1);
    assign w_byte_done = w_stop_tick && r_rxs;
    assign w_frame_bad = w_stop_tick && !r_rxs;

    // Two-stage synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    // Frame FSM with bit timer; timer only runs inside a frame and never wraps past a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer <= '0;
                        r_idx   <= 3'd0;
                        r_state <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_state <= r_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_timer <= '0;
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Output holding register: a new byte always wins; overrun only if the old one was not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_frame_bad;
            r_ovr  <= w_byte_done && r_valid && !rx_ready;
            if (w_byte_done) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 with an 8-clock bit period.
module tb_uart_rx_8n1;

    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0;
    int n_ovr  = 0;

    logic [7:0] exp_q[$];
    logic       p_valid = 1'b0;
    logic       p_acc   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called aligned to a falling clock edge; returns aligned, line high.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a byte is "presented" when valid rises, follows an accept, or data changes under valid.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (rst_n) begin
            if (rx_valid && (!p_valid || p_acc || rx_data != p_data)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got=%02h expected=none (t=%0t)", rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_byte", {24'h0, rx_data}, {24'h0, e});
                end
            end
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
        end
        p_valid = rx_valid;
        p_acc   = rx_valid && rx_ready;
        p_data  = rx_data;
    end

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        idle(3);
        chk("rst_valid", {31'h0, rx_valid}, 32'd0);
        chk("rst_data", {24'h0, rx_data}, 32'h00);
        chk("rst_ferr", {31'h0, frame_err}, 32'd0);
        chk("rst_ovr", {31'h0, overrun}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // 1: single byte held with ready low
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        idle(4 * CPB);
        chk("t1_valid", {31'h0, rx_valid}, 32'd1);
        chk("t1_data", {24'h0, rx_data}, 32'hA5);
        chk("t1_ferr_cnt", n_ferr, 0);
        chk("t1_ovr_cnt", n_ovr, 0);
        idle(20);
        chk("t1_held", {31'h0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(1);
        chk("t1_consumed", {31'h0, rx_valid}, 32'd0);
        chk("t1_data_hold", {24'h0, rx_data}, 32'hA5);

        // 2: short glitch is rejected
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(5 * CPB);
        chk("t2_valid", {31'h0, rx_valid}, 32'd0);
        chk("t2_ferr_cnt", n_ferr, 0);
        chk("t2_ovr_cnt", n_ovr, 0);

        // 3: bad stop bit, then a good byte
        send_byte(8'h3C, 1'b0);
        idle(4 * CPB);
        chk("t3_valid", {31'h0, rx_valid}, 32'd0);
        chk("t3_ferr_cnt", n_ferr, 1);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle(4 * CPB);
        chk("t3_good_data", {24'h0, rx_data}, 32'h55);
        chk("t3_ferr_once", n_ferr, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(2);

        // 4: back-to-back with ready low overruns once
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(4 * CPB);
        chk("t4_ovr_cnt", n_ovr, 1);
        chk("t4_data", {24'h0, rx_data}, 32'h22);
        chk("t4_valid", {31'h0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        idle(2);

        // 5: streaming with ready held high
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h81, 1'b1);
        idle(4 * CPB);
        chk("t5_valid", {31'h0, rx_valid}, 32'd0);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_ferr_cnt", n_ferr, 1);
        chk("t5_ovr_cnt", n_ovr, 1);
        chk("t5_last_data", {24'h0, rx_data}, 32'h81);
        rx_ready = 1'b0;

        // 6: reset during data bit 4 of 0x96
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 8'h01;
            idle(CPB);
        end
        rx = 1'b1;
        idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", {24'h0, rx_data}, 32'h00);
        chk("t6_rst_valid", {31'h0, rx_valid}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(20);
        chk("t6_no_output", {31'h0, rx_valid}, 32'd0);
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        idle(4 * CPB);
        chk("t6_data", {24'h0, rx_data}, 32'h42);
        chk("t6_valid", {31'h0, rx_valid}, 32'd1);
        chk("t6_ferr_cnt", n_ferr, 1);
        chk("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
